// File: rtl/puf_response_sequencer_if.sv
// Host/PUF-side signal bundle for puf_response_sequencer.
//   slave  : sequencer view (drives busy, challenge, puf_trigger, resp_*)
//   master : host + PUF view (drives start, seed, xor_response, resp_ready)
// Ports carried:
//   start, seed[CHAL_W]        run request and initial challenge
//   busy                       sequencer not idle
//   challenge[CHAL_W]          challenge applied to the PUF chains
//   puf_trigger                one-cycle evaluation launch pulse
//   xor_response               combined PUF response bit
//   resp_data[RESP_BITS]       collected response word
//   resp_valid, resp_ready     response word handshake
interface puf_response_sequencer_if #(
  parameter int CHAL_W    = 64,
  parameter int RESP_BITS = 32
);
  logic                 start;
  logic [CHAL_W-1:0]    seed;
  logic                 busy;
  logic [CHAL_W-1:0]    challenge;
  logic                 puf_trigger;
  logic                 xor_response;
  logic [RESP_BITS-1:0] resp_data;
  logic                 resp_valid;
  logic                 resp_ready;

  modport slave (
    input  start, seed, xor_response, resp_ready,
    output busy, challenge, puf_trigger, resp_data, resp_valid
  );

  modport master (
    output start, seed, xor_response, resp_ready,
    input  busy, challenge, puf_trigger, resp_data, resp_valid
  );
endinterface

// File: rtl/puf_response_sequencer.sv
// Challenge/response sequencer for the 6-chain PDL PUF.
// For each response bit the current challenge is evaluated EVAL_CNT times
// (trigger pulse, SETTLE_CYC wait, sample of the XOR-combined response),
// the samples are majority-voted, and the voted bit is shifted into the
// response word (first bit ends at the MSB). Between bits the challenge
// advances through a Fibonacci LFSR. The finished word is offered to the
// host with a valid/ready handshake.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    puf_response_sequencer_if.slave (start/seed, busy, challenge,
//          puf_trigger, xor_response, resp_data/resp_valid/resp_ready)
module puf_response_sequencer #(
  parameter int                CHAL_W     = 64,
  parameter int                RESP_BITS  = 32,
  parameter int                EVAL_CNT   = 5,
  parameter int                SETTLE_CYC = 8,
  parameter logic [CHAL_W-1:0] TAPS       = CHAL_W'(64'hD800_0000_0000_0000)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  puf_response_sequencer_if.slave   bus
);

  // Counter widths; index counters keep at least one bit for degenerate sizes.
  localparam int OW = $clog2(EVAL_CNT + 1);
  localparam int EW = (EVAL_CNT  > 1) ? $clog2(EVAL_CNT)  : 1;
  localparam int BW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int SW = $clog2(SETTLE_CYC + 1);

  localparam logic [EW-1:0] EVAL_LAST   = EW'(EVAL_CNT - 1);
  localparam logic [BW-1:0] BIT_LAST    = BW'(RESP_BITS - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [OW-1:0] HALF        = OW'(EVAL_CNT / 2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FIRE   = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    VOTE   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t                 state_q,     state_d;
  logic [CHAL_W-1:0]      challenge_q, challenge_d;
  logic [RESP_BITS-1:0]   resp_data_q, resp_data_d;
  logic [OW-1:0]          ones_q,      ones_d;
  logic [EW-1:0]          eval_idx_q,  eval_idx_d;
  logic [BW-1:0]          bit_idx_q,   bit_idx_d;
  logic [SW-1:0]          settle_q,    settle_d;

  // Strict majority of EVAL_CNT samples (EVAL_CNT is odd, so no ties).
  function automatic logic majority(input logic [OW-1:0] ones);
    return ones > HALF;
  endfunction

  // One Fibonacci LFSR step: shift left, feedback = parity of tapped bits.
  function automatic logic [CHAL_W-1:0] lfsr_next(input logic [CHAL_W-1:0] c);
    return (c << 1) | CHAL_W'(^(c & TAPS));
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      challenge_q <= '0;
      resp_data_q <= '0;
      ones_q      <= '0;
      eval_idx_q  <= '0;
      bit_idx_q   <= '0;
      settle_q    <= '0;
    end else begin
      state_q     <= state_d;
      challenge_q <= challenge_d;
      resp_data_q <= resp_data_d;
      ones_q      <= ones_d;
      eval_idx_q  <= eval_idx_d;
      bit_idx_q   <= bit_idx_d;
      settle_q    <= settle_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    challenge_d = challenge_q;
    resp_data_d = resp_data_q;
    ones_d      = ones_q;
    eval_idx_d  = eval_idx_q;
    bit_idx_d   = bit_idx_q;
    settle_d    = settle_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          // An all-zero state would lock the LFSR, so it is replaced by 1.
          challenge_d = (bus.seed == '0) ? CHAL_W'(1) : bus.seed;
          bit_idx_d   = '0;
          eval_idx_d  = '0;
          ones_d      = '0;
          state_d     = FIRE;
        end
      end
      FIRE: begin
        settle_d = '0;
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      SAMPLE: begin
        ones_d = ones_q + OW'(bus.xor_response);
        if (eval_idx_q == EVAL_LAST) begin
          state_d = VOTE;
        end else begin
          eval_idx_d = eval_idx_q + EW'(1);
          state_d    = FIRE;
        end
      end
      VOTE: begin
        resp_data_d = (resp_data_q << 1) | RESP_BITS'(majority(ones_q));
        ones_d      = '0;
        eval_idx_d  = '0;
        if (bit_idx_q == BIT_LAST) begin
          state_d = DONE;
        end else begin
          bit_idx_d   = bit_idx_q + BW'(1);
          challenge_d = lfsr_next(challenge_q);
          state_d     = FIRE;
        end
      end
      DONE: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.puf_trigger = (state_q == FIRE);
  assign bus.resp_valid  = (state_q == DONE);
  assign bus.challenge   = challenge_q;
  assign bus.resp_data   = resp_data_q;

endmodule

// File: tb/tb_puf_response_sequencer.sv
// Bench for puf_response_sequencer with RESP_BITS=4, EVAL_CNT=3, SETTLE_CYC=2.
// The reference model derives trigger cycles, sample cycles, challenges and
// the voted response word from the cycle arithmetic of the run.
module tb_puf_response_sequencer;
  localparam int CW       = 64;
  localparam int RB       = 4;
  localparam int EC       = 3;
  localparam int SC       = 2;
  localparam int PER_EVAL = SC + 2;
  localparam int PER_BIT  = EC * PER_EVAL + 1;
  localparam int RUN      = RB * PER_BIT;
  localparam logic [CW-1:0] TB_TAPS = 64'hD800_0000_0000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;
  logic xr [RUN];

  always #5 clk = ~clk;

  puf_response_sequencer_if #(.CHAL_W(CW), .RESP_BITS(RB)) bus ();

  puf_response_sequencer #(
    .CHAL_W(CW), .RESP_BITS(RB), .EVAL_CNT(EC), .SETTLE_CYC(SC), .TAPS(TB_TAPS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] lfsr_ref(input logic [CW-1:0] c);
    return {c[CW-2:0], ^(c & TB_TAPS)};
  endfunction

  // mode 0: response constantly 1; mode 1: directed sample pattern with 1s
  // between samples; mode 2: fully random. pulse_k/abort_k: cycle index of
  // a stray start pulse / an asynchronous reset (-1 for none).
  task automatic run(input logic [CW-1:0] seed_v, input int mode, input int pulse_k,
                     input int abort_k, output logic [RB-1:0] exp);
    logic [11:0]   pat;
    logic [CW-1:0] chal;
    int            ones;
    int            r;
    logic          fire;
    pat = 12'b101_001_110_111;
    for (int k = 0; k < RUN; k++) begin
      xr[k] = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (mode == 1) begin
      for (int b = 0; b < RB; b++)
        for (int e = 0; e < EC; e++)
          xr[b*PER_BIT + e*PER_EVAL + SC + 1] = pat[11 - (b*EC + e)];
    end
    exp = '0;
    for (int b = 0; b < RB; b++) begin
      ones = 0;
      for (int e = 0; e < EC; e++) ones += int'(xr[b*PER_BIT + e*PER_EVAL + SC + 1]);
      exp = {exp[RB-2:0], (ones > EC/2)};
    end

    @(posedge clk); #1;
    bus.seed  = seed_v;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.seed  = {$urandom, $urandom};
    chal = (seed_v == '0) ? CW'(1) : seed_v;
    for (int k = 0; k < RUN; k++) begin
      r = k % PER_BIT;
      if (r == 0 && k != 0) chal = lfsr_ref(chal);
      fire = (r < EC*PER_EVAL) && (r % PER_EVAL == 0);
      bus.xor_response = xr[k];
      if (k == abort_k) begin
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_busy",      64'(bus.busy),        64'd0);
        chk("async_rst_trigger",   64'(bus.puf_trigger), 64'd0);
        chk("async_rst_challenge", 64'(bus.challenge),   64'd0);
        chk("async_rst_resp_data", 64'(bus.resp_data),   64'd0);
        chk("async_rst_valid",     64'(bus.resp_valid),  64'd0);
        exp = '0;
        return;
      end
      if (k == pulse_k) begin
        bus.start = 1'b1;
        bus.seed  = 64'hDEAD_BEEF_0000_0007;
      end else begin
        bus.start = 1'b0;
      end
      chk($sformatf("trigger_k%0d", k),   64'(bus.puf_trigger), 64'(fire));
      chk($sformatf("challenge_k%0d", k), 64'(bus.challenge),   64'(chal));
      chk($sformatf("valid_k%0d", k),     64'(bus.resp_valid),  64'd0);
      chk($sformatf("busy_k%0d", k),      64'(bus.busy),        64'd1);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    chk("done_valid", 64'(bus.resp_valid), 64'd1);
    chk("done_data",  64'(bus.resp_data),  64'(exp));
    chk("done_busy",  64'(bus.busy),       64'd1);
  endtask

  task automatic handshake(input int hold, input logic [RB-1:0] exp);
    for (int i = 0; i < hold; i++) begin
      bus.resp_ready = 1'b0;
      bus.start      = (i == 3);
      bus.seed       = 64'h55;
      chk($sformatf("hold_valid_%0d", i), 64'(bus.resp_valid), 64'd1);
      chk($sformatf("hold_data_%0d", i),  64'(bus.resp_data),  64'(exp));
      @(posedge clk); #1;
    end
    bus.start      = 1'b0;
    bus.resp_ready = 1'b1;
    chk("pre_ack_valid", 64'(bus.resp_valid), 64'd1);
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk("post_ack_valid", 64'(bus.resp_valid), 64'd0);
    chk("post_ack_busy",  64'(bus.busy),       64'd0);
    @(posedge clk); #1;
    chk("idle_busy",    64'(bus.busy),        64'd0);
    chk("idle_trigger", 64'(bus.puf_trigger), 64'd0);
  endtask

  initial begin
    logic [RB-1:0] exp;
    bus.start        = 1'b0;
    bus.seed         = '0;
    bus.xor_response = 1'b0;
    bus.resp_ready   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",      64'(bus.busy),        64'd0);
    chk("reset_trigger",   64'(bus.puf_trigger), 64'd0);
    chk("reset_challenge", 64'(bus.challenge),   64'd0);
    chk("reset_resp_data", 64'(bus.resp_data),   64'd0);
    chk("reset_valid",     64'(bus.resp_valid),  64'd0);
    rst_n = 1'b1;

    // Constant-1 response, seed 1: word 4'hF, challenges 1,2,4,8
    run(64'h1, 0, -1, -1, exp);
    chk("all_ones_word", 64'(bus.resp_data), 64'hF);
    handshake(2, exp);

    // Directed vote patterns with non-sample noise: word 4'b1011
    run(64'h1, 1, -1, -1, exp);
    chk("pattern_word", 64'(bus.resp_data), 64'hB);
    handshake(10, exp);

    // Seed 0 is replaced by 1
    run(64'h0, 2, -1, -1, exp);
    handshake(1, exp);

    // Stray start during SETTLE of bit 1
    run(64'h1234_5678_9ABC_DEF1, 2, PER_BIT + 1, -1, exp);
    handshake(4, exp);

    // Random runs
    for (int i = 0; i < 3; i++) begin
      run({$urandom, $urandom}, 2, -1, -1, exp);
      handshake(i + 1, exp);
    end

    // Asynchronous reset in SETTLE of bit 2, then a fresh run with seed 5
    run(64'h1, 0, -1, 2*PER_BIT + 1, exp);
    @(posedge clk); #1;
    chk("rst_hold_busy", 64'(bus.busy), 64'd0);
    rst_n = 1'b1;
    run(64'h5, 2, -1, -1, exp);
    handshake(2, exp);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/puf_response_sequencer.md
Name: puf_response_sequencer

Overview:
Sequences challenge/response generation for the 6-chain PDL PUF. It drives the challenge bus and a one-cycle evaluation trigger, waits a fixed settle time, and samples the single XOR-combined response bit. Each response bit is evaluated EVAL_CNT times and majority-voted. Voted bits are shifted into a RESP_BITS-wide response word, which is handed to the host over a valid/ready handshake. Sits between the host/UART command logic and the PUF challenge inputs plus output XOR network.

Parameters:
CHAL_W, 64, challenge bus width
RESP_BITS, 32, response bits collected per run (≥1)
EVAL_CNT, 5, evaluations per bit for majority vote (odd, ≥1)
SETTLE_CYC, 8, wait cycles between trigger and sample (≥1)
TAPS, 64'hD800_0000_0000_0000, LFSR feedback mask (x^64+x^63+x^61+x^60+1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  run request; accepted only in IDLE
seed  in  CHAL_W  initial challenge, sampled on start acceptance
busy  out  1  high in every state except IDLE
challenge  out  CHAL_W  challenge applied to the PUF chains
puf_trigger  out  1  one-cycle evaluation launch pulse
xor_response  in  1  combined PUF response bit from the output network
resp_data  out  RESP_BITS  collected response word; first bit ends up at the MSB
resp_valid  out  1  response word available
resp_ready  in  1  host accepts the response word

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, challenge, puf_trigger, resp_data and resp_valid are all 0; all counters are 0. Effective immediately, including mid-run. Any partial result is discarded.
- IDLE: start=1 → challenge<=seed (if seed==0, load 1 to avoid LFSR lock-up); bit_idx, eval_idx and ones are cleared → FIRE.
- FIRE (1 cycle): puf_trigger=1 → SETTLE; settle counter cleared.
- SETTLE (SETTLE_CYC cycles): puf_trigger=0 → SAMPLE.
- SAMPLE (1 cycle): ones<=ones+xor_response. If eval_idx==EVAL_CNT-1 → VOTE; else eval_idx++ → FIRE.
- VOTE (1 cycle):
  - bit = (ones > EVAL_CNT/2).
  - resp_data <= {resp_data[RESP_BITS-2:0], bit}.
  - ones and eval_idx are cleared.
  - If bit_idx==RESP_BITS-1 → DONE.
  - Otherwise bit_idx++, challenge <= {challenge[CHAL_W-2:0], ^(challenge & TAPS)} → FIRE.
- DONE: resp_valid=1; resp_data is held stable. When resp_ready=1, resp_valid drops on that edge → IDLE. resp_valid is never withdrawn before the handshake completes.
- Challenge changes only on start acceptance and in VOTE. It is stable from each FIRE through its SAMPLE.
- xor_response is sampled only in SAMPLE and ignored in all other states.
- start is ignored in every state except IDLE, including DONE. No queuing.
- Width rules:
  - ones counter: clog2(EVAL_CNT+1) bits, no overflow.
  - bit_idx: clog2(RESP_BITS) bits.
  - settle counter: clog2(SETTLE_CYC+1) bits.
- Latency:
  - Per evaluation: SETTLE_CYC+2 cycles.
  - Per bit: EVAL_CNT*(SETTLE_CYC+2)+1 cycles.
  - resp_valid rises RESP_BITS*(EVAL_CNT*(SETTLE_CYC+2)+1) cycles after the first puf_trigger cycle. Defaults: 1632.
- busy rises the cycle after start acceptance and falls the cycle after the resp_ready handshake.

Test Plan:
1. Params RESP_BITS=4, EVAL_CNT=3, SETTLE_CYC=2; xor_response=1 constant; seed=1, start → puf_trigger pulses 12 times, one per 4 cycles within each bit; resp_valid rises exactly 52 cycles after the first puf_trigger; resp_data=4'hF.
2. Same params; per-bit sample patterns (1,0,1), (0,0,1), (1,1,0), (1,1,1) → resp_data=4'b1011; xor_response toggled outside SAMPLE cycles has no effect.
3. Defaults, seed=64'h1 → challenge=1 for bit 0, 64'h2 for bit 1, 64'h4 for bit 2; seed=0 → challenge=1 for bit 0.
4. Hold resp_ready=0 for 10 cycles in DONE and pulse start → resp_valid and resp_data hold, start is ignored; resp_ready=1 → next cycle resp_valid=0, busy=0, state IDLE.
5. Pulse start during SETTLE of bit 1 → ignored, no restart, bit count unchanged; final result matches a run without the extra pulse.
6. Drive rst_n=0 mid-SETTLE (asynchronously, between edges) → busy, puf_trigger, challenge, resp_data and resp_valid go to 0 without a clock edge; after release, a new start with seed=5 completes normally.
